// File: rtl/key_event_decoder.sv
// Key event decoder: turns debounced press/release pulses into single-click,
// double-click, long-press and auto-repeat pulses using one shared 26-bit timer.
module key_event_decoder #(
  parameter int unsigned LONG_TIME   = 50_000_000,
  parameter int unsigned DOUBLE_GAP  = 15_000_000,
  parameter int unsigned REPEAT_TIME = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_p_flag,
  input  logic key_r_flag,
  output logic short_flag,
  output logic double_flag,
  output logic long_flag,
  output logic repeat_flag,
  output logic busy
);

  localparam logic [25:0] LONG_LAST   = 26'(LONG_TIME - 1);
  localparam logic [25:0] GAP_LAST    = 26'(DOUBLE_GAP - 1);
  localparam logic [25:0] REPEAT_LAST = 26'(REPEAT_TIME - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [25:0] cnt, cnt_next;
  logic        short_next, double_next, long_next, repeat_next;
  logic        press, release_ev;

  // Simultaneous press and release cancel each other out.
  assign press      = key_p_flag & ~key_r_flag;
  assign release_ev = key_r_flag & ~key_p_flag;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt + 26'd1;
    short_next  = 1'b0;
    double_next = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (press) state_next = PRESS1;
      end
      PRESS1: begin
        // The release is checked first so it wins over a coincident timeout.
        if (release_ev) begin
          state_next = WAIT2;
          cnt_next   = '0;
        end else if (cnt == LONG_LAST) begin
          state_next = LONG_HOLD;
          cnt_next   = '0;
          long_next  = 1'b1;
        end
      end
      LONG_HOLD: begin
        if (release_ev) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == REPEAT_LAST) begin
          cnt_next    = '0;
          repeat_next = 1'b1;
        end
      end
      WAIT2: begin
        if (press) begin
          state_next = PRESS2;
          cnt_next   = '0;
        end else if (cnt == GAP_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          short_next = 1'b1;
        end
      end
      PRESS2: begin
        // No timeout here, so the timer is parked rather than left to wrap.
        cnt_next = '0;
        if (release_ev) begin
          state_next  = IDLE;
          double_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      short_flag  <= 1'b0;
      double_flag <= 1'b0;
      long_flag   <= 1'b0;
      repeat_flag <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      short_flag  <= short_next;
      double_flag <= double_next;
      long_flag   <= long_next;
      repeat_flag <= repeat_next;
    end
  end

  assign busy = (state != IDLE);

endmodule
